// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame length
// and the odd-parity rule applied to the data and parity bits.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    localparam int FRAME_BITS = 11;

    // True when the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head, pop strobe, fill level
// and the sticky error flags with their clear strobe.
interface ps2_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();

    logic                  rdy;
    logic [7:0]            data;
    logic                  done;
    logic [DEPTH_LOG2:0]   level;
    logic                  perr;
    logic                  ferr;
    logic                  ovf;
    logic                  err_clr;

    modport master (
        output rdy, data, level, perr, ferr, ovf,
        input  done, err_clr
    );

    modport slave (
        input  rdy, data, level, perr, ferr, ovf,
        output done, err_clr
    );

endinterface

// File: rtl/ps2_rx_fifo_sync_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised input after it has differed for FILTER cycles.
module sync_filter #(
    parameter int FILTER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt
);

    localparam int CNT_W = $clog2(FILTER + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the
    // synchroniser chain a chain rather than a wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != filt) begin
                if (cnt == CNT_W'(FILTER - 1)) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front end: filtered clock edge detect, 11-bit frame capture
// with start/parity/stop checks and timeout, and a byte FIFO with sticky flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int FILTER     = 4,
    parameter int TIMEOUT    = 50000,
    parameter int PARITY_EN  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PS2C,
    input  logic          PS2D,
    output logic          shift,
    ps2_rx_fifo_if.master bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic fc;
    logic fc_d;
    logic dsync;

    sync_filter #(.FILTER(FILTER)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (PS2C),
        .filt (fc)
    );

    // A one-cycle filter is a pass-through after the synchroniser.
    sync_filter #(.FILTER(1)) u_dat_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (PS2D),
        .filt (dsync)
    );

    always_ff @(posedge clk) begin
        if (rst) fc_d <= 1'b1;
        else     fc_d <= fc;
    end

    assign shift = fc_d & ~fc;

    // Frame receiver
    state_t          state_q, state_d;
    logic [3:0]      bitcnt_q;
    logic [10:0]     frame_q;
    logic [TW-1:0]   tcnt_q;
    logic            timeout;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (shift && !dsync) state_d = RECV;
            end
            RECV: begin
                if (shift) begin
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) state_d = CHECK;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            frame_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (shift) frame_q <= {dsync, frame_q[10:1]};
            // Parked at 1 while idle so the start bit is already counted on entry.
            if (state_q == IDLE) bitcnt_q <= 4'd1;
            else if (shift)      bitcnt_q <= bitcnt_q + 4'd1;
            if (state_q != RECV || shift) tcnt_q <= '0;
            else                          tcnt_q <= tcnt_q + TW'(1);
        end
    end

    // Frame decision and FIFO control
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [LW-1:0]         level_q;
    logic                  perr_q, ferr_q, ovf_q;
    logic                  in_check, frame_ok, par_ok, good;
    logic                  rdy, full, pop, push;
    logic                  set_perr, set_ferr, set_ovf;

    assign in_check = (state_q == CHECK);
    assign frame_ok = ~frame_q[0] & frame_q[10];
    assign par_ok   = (PARITY_EN == 0) || odd_parity_ok(frame_q[9:1]);
    assign good     = frame_ok & par_ok;

    assign rdy  = (level_q != '0);
    assign full = (level_q == LW'(DEPTH));
    assign pop  = bus.done & rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = in_check & good & (~full | pop);

    assign set_ovf  = in_check & good & full & ~pop;
    assign set_ferr = (in_check & ~frame_ok) | timeout;
    assign set_perr = in_check & ~par_ok;

    // NOTE: the byte storage has no reset; entries are only ever read below
    // level_q, which is reset, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= frame_q[8:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (!push && pop) level_q <= level_q - LW'(1);
        end
    end

    // Sticky flags: a new error outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (set_perr)         perr_q <= 1'b1;
            else if (bus.err_clr) perr_q <= 1'b0;
            if (set_ferr)         ferr_q <= 1'b1;
            else if (bus.err_clr) ferr_q <= 1'b0;
            if (set_ovf)          ovf_q  <= 1'b1;
            else if (bus.err_clr) ovf_q  <= 1'b0;
        end
    end

    assign bus.rdy   = rdy;
    assign bus.data  = mem[rptr_q];
    assign bus.level = level_q;
    assign bus.perr  = perr_q;
    assign bus.ferr  = ferr_q;
    assign bus.ovf   = ovf_q;

endmodule
